// File: rtl/store_write_buffer.sv
// MEM-stage store path: aligns SB/SH/SW into lane-aligned words with byte enables, queues them
// in a FIFO drained over a valid/ready port. Optional macro STORE_ALIGN_CHECK_EN drops misaligned stores.
module store_write_buffer #(
    parameter int NBITS = 32,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_Store,
    input  logic [1:0]                 i_Size,
    input  logic [NBITS-1:0]           i_Addr,
    input  logic [NBITS-1:0]           i_Data,
    input  logic                       i_Load,
    input  logic [NBITS-1:0]           i_LoadAddr,
    output logic                       o_Stall,
    output logic                       o_MemWe,
    output logic [NBITS-1:0]           o_MemAddr,
    output logic [NBITS-1:0]           o_MemData,
    output logic [3:0]                 o_MemBe,
    input  logic                       i_MemReady,
    output logic                       o_Empty,
`ifdef STORE_ALIGN_CHECK_EN
    output logic                       o_Misaligned,
`endif
    output logic [$clog2(DEPTH):0]     o_Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [NBITS-1:0] addr_q [DEPTH];
    logic [NBITS-1:0] data_q [DEPTH];
    logic [3:0]       be_q   [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;

    logic [NBITS-1:0] al_data;
    logic [3:0]       al_be;
    logic             full;
    logic             empty;
    logic             hazard;
    logic             misaligned;
    logic             push;
    logic             pop;
    logic             unused_ok;

    assign unused_ok = ^{i_LoadAddr[1:0]};

    always_comb begin
        al_data = i_Data;
        al_be   = 4'b1111;
        case (i_Size)
            2'b00: begin
                al_data = NBITS'({4{i_Data[7:0]}});
                al_be   = 4'b0001 << i_Addr[1:0];
            end
            2'b01: begin
                al_data = NBITS'({2{i_Data[15:0]}});
                al_be   = i_Addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                al_data = i_Data;
                al_be   = 4'b1111;
            end
        endcase
    end

`ifdef STORE_ALIGN_CHECK_EN
    assign misaligned = (i_Size == 2'b01 && i_Addr[0]) || (i_Size[1] && i_Addr[1:0] != 2'b00);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) o_Misaligned <= 1'b0;
        else            o_Misaligned <= i_Store && !i_Load && misaligned;
    end
`else
    assign misaligned = 1'b0;
`endif

    // Every valid entry is compared, including a head that pops this same cycle.
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_Load && vld_q[i] && addr_q[i][NBITS-1:2] == i_LoadAddr[NBITS-1:2])
                hazard = 1'b1;
        end
    end

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    // A store alongside a load is never enqueued; only the load check matters then.
    assign push    = i_Store && !i_Load && !full && !hazard && !misaligned;
    assign pop     = !empty && i_MemReady;

    assign o_Stall   = i_reset_n && ((i_Store && full && !misaligned) || hazard);
    assign o_MemWe   = !empty;
    assign o_MemAddr = addr_q[rd_ptr];
    assign o_MemData = data_q[rd_ptr];
    assign o_MemBe   = be_q[rd_ptr];
    assign o_Empty   = empty;
    assign o_Count   = count_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                addr_q[wr_ptr] <= {i_Addr[NBITS-1:2], 2'b00};
                data_q[wr_ptr] <= al_data;
                be_q[wr_ptr]   <= al_be;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer (DEPTH=4, NBITS=32).
module tb_store_write_buffer;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_Store;
    logic [1:0]  i_Size;
    logic [31:0] i_Addr;
    logic [31:0] i_Data;
    logic        i_Load;
    logic [31:0] i_LoadAddr;
    logic        o_Stall;
    logic        o_MemWe;
    logic [31:0] o_MemAddr;
    logic [31:0] o_MemData;
    logic [3:0]  o_MemBe;
    logic        i_MemReady;
    logic        o_Empty;
    logic [2:0]  o_Count;
`ifdef STORE_ALIGN_CHECK_EN
    logic        o_Misaligned;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    store_write_buffer #(.NBITS(32), .DEPTH(4)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_Store(i_Store), .i_Size(i_Size),
        .i_Addr(i_Addr), .i_Data(i_Data), .i_Load(i_Load), .i_LoadAddr(i_LoadAddr),
        .o_Stall(o_Stall), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr), .o_MemData(o_MemData),
        .o_MemBe(o_MemBe), .i_MemReady(i_MemReady), .o_Empty(o_Empty),
`ifdef STORE_ALIGN_CHECK_EN
        .o_Misaligned(o_Misaligned),
`endif
        .o_Count(o_Count)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        i_Store = 1'b1; i_Size = sz; i_Addr = a; i_Data = d;
    endtask

    task automatic idle();
        i_Store = 1'b0; i_Load = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        i_reset_n = 1'b0;
        step();
        i_reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (o_Empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", o_Empty); end
        n_cmp++; if (o_Count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_Count); end
        n_cmp++; if ({o_MemWe, o_MemAddr, o_MemData, o_MemBe} !== '0) begin n_fail++;
            $display("FAIL reset_memport: got we=%b a=%h d=%h be=%b want all 0", o_MemWe, o_MemAddr, o_MemData, o_MemBe); end
        n_cmp++; if (o_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", o_Stall); end
        // fill to 4 with memory blocked, then reset while a store is pending at full
        i_MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_store(2'b11, 32'h40 + 32'(4 * i), 32'h11 * 32'(i + 1));
            step();
        end
        i_Store = 1'b0; #1;
        n_cmp++; if (o_Count !== 3'd4) begin n_fail++; $display("FAIL reset_prefill: got %0d want 4", o_Count); end
        set_store(2'b11, 32'h80, 32'h99);
        i_reset_n = 1'b0; #1;
        n_cmp++; if (o_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_gated: got %b want 0", o_Stall); end
        step();
        i_reset_n = 1'b1; idle(); #1;
        n_cmp++; if (o_Empty !== 1'b1 || o_Count !== 3'd0 || o_MemWe !== 1'b0) begin n_fail++;
            $display("FAIL reset_discard: got empty=%b count=%0d we=%b want 1/0/0", o_Empty, o_Count, o_MemWe); end
    endtask

    task automatic test_byte();
        do_reset();
        i_MemReady = 1'b1;
        set_store(2'b00, 32'h103, 32'h0000_00AB);
        n_cmp++; if (o_MemWe !== 1'b0) begin n_fail++; $display("FAIL sb_latency: got we=%b want 0", o_MemWe); end
        step();
        i_Store = 1'b0; #1;
        n_cmp++; if (o_MemWe !== 1'b1 || o_MemAddr !== 32'h100 || o_MemData !== 32'hABABABAB || o_MemBe !== 4'b1000) begin n_fail++;
            $display("FAIL sb_port: got we=%b a=%h d=%h be=%b want 1 00000100 abababab 1000", o_MemWe, o_MemAddr, o_MemData, o_MemBe); end
        step();
        n_cmp++; if (o_Empty !== 1'b1 || o_MemWe !== 1'b0) begin n_fail++;
            $display("FAIL sb_pop: got empty=%b we=%b want 1/0", o_Empty, o_MemWe); end
    endtask

    task automatic test_half_word();
        do_reset();
        i_MemReady = 1'b0;
        set_store(2'b01, 32'h202, 32'h0000_1234); step();
        set_store(2'b11, 32'h204, 32'hDEADBEEF); step();
        i_Store = 1'b0; #1;
        n_cmp++; if (o_Count !== 3'd2) begin n_fail++; $display("FAIL shsw_count: got %0d want 2", o_Count); end
        step(); step();
        n_cmp++; if (o_MemAddr !== 32'h200 || o_MemBe !== 4'b1100 || o_MemData !== 32'h12341234 || o_MemWe !== 1'b1) begin n_fail++;
            $display("FAIL sh_head_stable: got a=%h be=%b d=%h we=%b want 00000200 1100 12341234 1", o_MemAddr, o_MemBe, o_MemData, o_MemWe); end
        i_MemReady = 1'b1;
        step();
        n_cmp++; if (o_MemAddr !== 32'h204 || o_MemBe !== 4'b1111 || o_MemData !== 32'hDEADBEEF || o_Count !== 3'd1) begin n_fail++;
            $display("FAIL sw_second: got a=%h be=%b d=%h cnt=%0d want 00000204 1111 deadbeef 1", o_MemAddr, o_MemBe, o_MemData, o_Count); end
        step();
        n_cmp++; if (o_Empty !== 1'b1) begin n_fail++; $display("FAIL shsw_drained: got %b want 1", o_Empty); end
        // SH to the low half
        i_MemReady = 1'b0;
        set_store(2'b01, 32'h20, 32'hFFFF_5A5A); step();
        i_Store = 1'b0; #1;
        n_cmp++; if (o_MemBe !== 4'b0011 || o_MemData !== 32'h5A5A5A5A) begin n_fail++;
            $display("FAIL sh_low: got be=%b d=%h want 0011 5a5a5a5a", o_MemBe, o_MemData); end
    endtask

    task automatic test_full();
        logic [31:0] exp_a [4];
        logic [31:0] exp_d [4];
        do_reset();
        i_MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_store(2'b11, 32'h10 + 32'(4 * i), 32'(i + 1));
            step();
        end
        set_store(2'b11, 32'h20, 32'h5);
        i_MemReady = 1'b1; #1;
        n_cmp++; if (o_Stall !== 1'b1 || o_Count !== 3'd4) begin n_fail++;
            $display("FAIL full_stall: got stall=%b cnt=%0d want 1 4", o_Stall, o_Count); end
        step();
        i_MemReady = 1'b0; #1;
        n_cmp++; if (o_Count !== 3'd3 || o_Stall !== 1'b0 || o_MemAddr !== 32'h14) begin n_fail++;
            $display("FAIL full_pop_no_push: got cnt=%0d stall=%b a=%h want 3 0 00000014", o_Count, o_Stall, o_MemAddr); end
        step();
        i_Store = 1'b0; #1;
        n_cmp++; if (o_Count !== 3'd4) begin n_fail++; $display("FAIL full_retry: got %0d want 4", o_Count); end
        exp_a = '{32'h14, 32'h18, 32'h1C, 32'h20};
        exp_d = '{32'h2, 32'h3, 32'h4, 32'h5};
        i_MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_MemWe !== 1'b1 || o_MemAddr !== exp_a[i] || o_MemData !== exp_d[i]) begin n_fail++;
                $display("FAIL drain_order%0d: got we=%b a=%h d=%h want 1 %h %h", i, o_MemWe, o_MemAddr, o_MemData, exp_a[i], exp_d[i]); end
            step();
        end
        n_cmp++; if (o_Empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", o_Empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_MemReady = 1'b1;
        set_store(2'b11, 32'h500, 32'hA0); step();
        set_store(2'b10, 32'h504, 32'hA1); #1;
        n_cmp++; if (o_Count !== 3'd1 || o_MemAddr !== 32'h500) begin n_fail++;
            $display("FAIL b2b_first: got cnt=%0d a=%h want 1 00000500", o_Count, o_MemAddr); end
        step();
        set_store(2'b00, 32'h509, 32'h77); #1;
        n_cmp++; if (o_Count !== 3'd1 || o_MemAddr !== 32'h504 || o_MemBe !== 4'b1111 || o_MemData !== 32'hA1) begin n_fail++;
            $display("FAIL b2b_pushpop: got cnt=%0d a=%h be=%b d=%h want 1 00000504 1111 000000a1", o_Count, o_MemAddr, o_MemBe, o_MemData); end
        step();
        i_Store = 1'b0; #1;
        n_cmp++; if (o_MemAddr !== 32'h508 || o_MemBe !== 4'b0010 || o_MemData !== 32'h77777777) begin n_fail++;
            $display("FAIL b2b_byte: got a=%h be=%b d=%h want 00000508 0010 77777777", o_MemAddr, o_MemBe, o_MemData); end
        step();
    endtask

    task automatic test_hazard();
        do_reset();
        i_MemReady = 1'b0;
        set_store(2'b11, 32'h300, 32'h55); step();
        i_Store = 1'b0; i_Load = 1'b1; i_LoadAddr = 32'h302; #1;
        n_cmp++; if (o_Stall !== 1'b1) begin n_fail++; $display("FAIL hz_hit: got %b want 1", o_Stall); end
        step();
        n_cmp++; if (o_Stall !== 1'b1 || o_Count !== 3'd1) begin n_fail++;
            $display("FAIL hz_hold: got stall=%b cnt=%0d want 1 1", o_Stall, o_Count); end
        i_LoadAddr = 32'h304; #1;
        n_cmp++; if (o_Stall !== 1'b0) begin n_fail++; $display("FAIL hz_miss: got %b want 0", o_Stall); end
        i_LoadAddr = 32'h302; i_MemReady = 1'b1; #1;
        n_cmp++; if (o_Stall !== 1'b1) begin n_fail++; $display("FAIL hz_popping_head: got %b want 1", o_Stall); end
        step();
        n_cmp++; if (o_Stall !== 1'b0 || o_Empty !== 1'b1) begin n_fail++;
            $display("FAIL hz_release: got stall=%b empty=%b want 0 1", o_Stall, o_Empty); end
        idle();
    endtask

    task automatic test_misaligned();
        do_reset();
        i_MemReady = 1'b0;
        set_store(2'b11, 32'h401, 32'hCAFEF00D); #1;
        n_cmp++; if (o_Stall !== 1'b0) begin n_fail++; $display("FAIL mis_nostall: got %b want 0", o_Stall); end
        step();
        i_Store = 1'b0; #1;
`ifdef STORE_ALIGN_CHECK_EN
        n_cmp++; if (o_Misaligned !== 1'b1 || o_Count !== 3'd0) begin n_fail++;
            $display("FAIL mis_flag: got mis=%b cnt=%0d want 1 0", o_Misaligned, o_Count); end
        step();
        n_cmp++; if (o_Misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b want 0", o_Misaligned); end
`else
        n_cmp++; if (o_Count !== 3'd1 || o_MemAddr !== 32'h400 || o_MemBe !== 4'b1111 || o_MemData !== 32'hCAFEF00D) begin n_fail++;
            $display("FAIL mis_ignored: got cnt=%0d a=%h be=%b d=%h want 1 00000400 1111 cafef00d", o_Count, o_MemAddr, o_MemBe, o_MemData); end
`endif
    endtask

    initial begin
        i_reset_n = 1'b0; i_Store = 1'b0; i_Size = 2'b00; i_Addr = '0; i_Data = '0;
        i_Load = 1'b0; i_LoadAddr = '0; i_MemReady = 1'b0;
        test_reset();
        test_byte();
        test_half_word();
        test_full();
        test_back_to_back();
        test_hazard();
        test_misaligned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
